// File: rtl/mem_stage.sv
// MIPS memory stage + MEM/WB register with a LATENCY-cycle internal data memory; completes LATENCY edges after the request.
// Backpressure: mem_stall freezes all upstream stages for LATENCY-1 cycles per access; MEM/WB loads a bubble meanwhile.
module mem_stage #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'd1024,
   parameter int          LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic [4:0]  Dest_in,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] ST_value_in,
   output logic        mem_stall,
   output logic [31:0] mem_fwd,
   output logic        WB_EN_out,
   output logic        MEM_R_EN_out,
   output logic [4:0]  Dest_out,
   output logic [31:0] ALU_result_out,
   output logic [31:0] MEM_result,
   output logic        addr_err
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     mem_d [DEPTH];

   logic            wb_en_q, wb_en_d;
   logic            mem_r_en_q, mem_r_en_d;
   logic [4:0]      dest_q, dest_d;
   logic [31:0]     alu_result_q, alu_result_d;
   logic [31:0]     mem_result_q, mem_result_d;
   logic            addr_err_q, addr_err_d;

   logic            req, is_load, in_range, done;
   logic [31:0]     offset, rd_dat;
   logic [IW-1:0]   word_idx;

   assign mem_fwd  = ALU_result_in;
   assign req      = MEM_R_EN_in | MEM_W_EN_in;
   assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;
   assign offset   = ALU_result_in - BASE_ADDR;
   // A wrapped subtraction means the address sits below the memory window.
   assign in_range = (ALU_result_in >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH));
   assign word_idx = offset[IW+1:2];
   assign rd_dat   = in_range ? mem_q[word_idx] : 32'h0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (LATENCY == 1) begin
                  done = 1'b1;
               end else begin
                  mem_stall = 1'b1;
                  state_d   = BUSY;
                  cnt_d     = CW'(1);
               end
            end
         end
         BUSY: begin
            mem_stall = (cnt_q != LAST);
            if (cnt_q == LAST) begin
               done    = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (done && MEM_W_EN_in && in_range) begin
         mem_d[word_idx] = ST_value_in;
      end
   end

   always_comb begin
      wb_en_d      = 1'b0;
      mem_r_en_d   = 1'b0;
      dest_d       = '0;
      alu_result_d = '0;
      mem_result_d = '0;
      addr_err_d   = 1'b0;
      if (!mem_stall) begin
         wb_en_d      = WB_EN_in;
         mem_r_en_d   = is_load;
         dest_d       = Dest_in;
         alu_result_d = ALU_result_in;
         mem_result_d = (done && is_load) ? rd_dat : 32'h0;
         addr_err_d   = done & ~in_range;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wb_en_q      <= 1'b0;
         mem_r_en_q   <= 1'b0;
         dest_q       <= '0;
         alu_result_q <= '0;
         mem_result_q <= '0;
         addr_err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wb_en_q      <= wb_en_d;
         mem_r_en_q   <= mem_r_en_d;
         dest_q       <= dest_d;
         alu_result_q <= alu_result_d;
         mem_result_q <= mem_result_d;
         addr_err_q   <= addr_err_d;
         mem_q        <= mem_d;
      end
   end

   assign WB_EN_out      = wb_en_q;
   assign MEM_R_EN_out   = mem_r_en_q;
   assign Dest_out       = dest_q;
   assign ALU_result_out = alu_result_q;
   assign MEM_result     = mem_result_q;
   assign addr_err       = addr_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: four instances with LATENCY 1..4, table vectors, corner sequences and random ops vs. a word-array model.
module tb_mem_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        wb_i [4];
   logic        r_i  [4];
   logic        w_i  [4];
   logic [4:0]  d_i  [4];
   logic [31:0] a_i  [4];
   logic [31:0] v_i  [4];

   wire         stall [4];
   wire  [31:0] fwd   [4];
   wire         wb_o  [4];
   wire         r_o   [4];
   wire  [4:0]  d_o   [4];
   wire  [31:0] a_o   [4];
   wire  [31:0] res_o [4];
   wire         err_o [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_stage #(.DEPTH(64), .BASE_ADDR(32'd1024), .LATENCY(g + 1)) u_dut (
         .clk(clk), .rst(rst),
         .WB_EN_in(wb_i[g]), .MEM_R_EN_in(r_i[g]), .MEM_W_EN_in(w_i[g]),
         .Dest_in(d_i[g]), .ALU_result_in(a_i[g]), .ST_value_in(v_i[g]),
         .mem_stall(stall[g]), .mem_fwd(fwd[g]),
         .WB_EN_out(wb_o[g]), .MEM_R_EN_out(r_o[g]), .Dest_out(d_o[g]),
         .ALU_result_out(a_o[g]), .MEM_result(res_o[g]), .addr_err(err_o[g])
      );
   end

   int tests = 0;
   int fails = 0;
   logic [31:0] mdl [4][64];

   typedef struct packed {
      logic        wb;
      logic        r;
      logic        w;
      logic [4:0]  dest;
      logic [31:0] addr;
      logic [31:0] val;
      logic [3:0]  exp_stall;
      logic [31:0] exp_res;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      longint unsigned ua = 64'(a);
      if (ua < 1024) return 1'b0;
      return ((ua - 1024) / 4) < 64;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 64; j++) mdl[k][j] = 32'h0;
   endtask

   task automatic drive(input int k, input logic wb, input logic r, input logic w,
                        input logic [4:0] d, input logic [31:0] a, input logic [31:0] v);
      wb_i[k] = wb; r_i[k] = r; w_i[k] = w; d_i[k] = d; a_i[k] = a; v_i[k] = v;
   endtask

   // Presents one instruction and holds it until the access completes, then checks MEM/WB.
   task automatic run_op(input int k, input logic wb, input logic r, input logic w,
                         input logic [4:0] d, input logic [31:0] a, input logic [31:0] v,
                         output int nst, output logic [31:0] res);
      bit          done, ok, ld, rq;
      logic        s;
      int          idx;
      logic [31:0] exp_res;
      ld  = r & ~w;
      rq  = r | w;
      ok  = in_rng(a);
      idx = ok ? int'((a - 32'd1024) >> 2) : 0;
      exp_res = (ld && ok) ? mdl[k][idx] : 32'h0;
      @(negedge clk);
      drive(k, wb, r, w, d, a, v);
      #1 chk($sformatf("k%0d mem_fwd", k), fwd[k], a);
      nst  = 0;
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         s = stall[k];
         @(posedge clk);
         #1;
         if (s) begin
            nst++;
            chk($sformatf("k%0d bubble", k),
                {31'b0, |{wb_o[k], r_o[k], d_o[k], a_o[k], res_o[k], err_o[k]}}, 32'h0);
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL k%0d completion timeout: got stall stuck high expected completion", k);
      end
      chk($sformatf("k%0d stall cycles", k), 32'(nst), rq ? 32'(k) : 32'h0);
      chk($sformatf("k%0d WB_EN_out", k), {31'b0, wb_o[k]}, {31'b0, wb});
      chk($sformatf("k%0d MEM_R_EN_out", k), {31'b0, r_o[k]}, {31'b0, ld});
      chk($sformatf("k%0d Dest_out", k), {27'b0, d_o[k]}, {27'b0, d});
      chk($sformatf("k%0d ALU_result_out", k), a_o[k], a);
      chk($sformatf("k%0d MEM_result", k), res_o[k], exp_res);
      chk($sformatf("k%0d addr_err", k), {31'b0, err_o[k]}, {31'b0, rq & ~ok});
      res = res_o[k];
      if (w && ok) mdl[k][idx] = v;
   endtask

   task automatic idle(input int k);
      @(negedge clk);
      drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("k%0d addr_err drop", k), {31'b0, err_o[k]}, 32'h0);
      chk($sformatf("k%0d idle stall", k), {31'b0, stall[k]}, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] res;
      logic [31:0] addr;
      logic [1:0]  rw;

      tbl[0]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1028, 32'hDEADBEEF, 4'd1, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'd7, 32'd1028, 32'h0,        4'd1, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1020, 32'h11111111, 4'd1, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1280, 32'h22222222, 4'd1, 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'd2, 32'd1020, 32'h0,        4'd1, 32'h0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 5'd3, 32'd1280, 32'h0,        4'd1, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'd4, 32'd1032, 32'hA5A5A5A5, 4'd1, 32'h0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 5'd5, 32'd1032, 32'h0,        4'd1, 32'hA5A5A5A5};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd9, 32'h55,   32'h0,        4'd0, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'd6, 32'd1031, 32'h0,        4'd1, 32'hDEADBEEF};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 5'd8, 32'd1024, 32'h0,        4'd1, 32'h0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 5'd1, 32'd1276, 32'h0,        4'd1, 32'h0};

      rst = 1'b0;
      for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      clear_model();
      #12;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("k%0d reset stall", k), {31'b0, stall[k]}, 32'h0);
         chk($sformatf("k%0d reset outputs", k),
             {31'b0, |{wb_o[k], r_o[k], d_o[k], a_o[k], res_o[k], err_o[k]}}, 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a LATENCY=3 access.
      run_op(2, 1'b0, 1'b0, 1'b1, 5'd0, 32'd1024, 32'h11112222, n, res);
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 1'b0, 5'd5, 32'd1028, 32'h0);
      @(posedge clk);
      #1 chk("k2 busy before reset", {31'b0, stall[2]}, 32'h1);
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      rst = 1'b0;
      #1;
      chk("k2 reset stall", {31'b0, stall[2]}, 32'h0);
      chk("k2 reset outputs", {31'b0, |{wb_o[2], r_o[2], d_o[2], a_o[2], res_o[2], err_o[2]}}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      idle(2);
      run_op(2, 1'b1, 1'b1, 1'b0, 5'd4, 32'd1024, 32'h0, n, res);
      chk("k2 load after reset", res, 32'h0);
      idle(2);

      // LATENCY=2 vector table.
      for (int i = 0; i < 12; i++) begin
         run_op(1, tbl[i].wb, tbl[i].r, tbl[i].w, tbl[i].dest, tbl[i].addr, tbl[i].val, n, res);
         chk($sformatf("tbl%0d stall", i), 32'(n), {28'b0, tbl[i].exp_stall});
         chk($sformatf("tbl%0d result", i), res, tbl[i].exp_res);
      end
      idle(1);

      // LATENCY=1 store then load with no gap.
      run_op(0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd1024, 32'h12345678, n, res);
      run_op(0, 1'b1, 1'b1, 1'b0, 5'd12, 32'd1024, 32'h0, n, res);
      chk("k0 back-to-back load", res, 32'h12345678);
      chk("k0 back-to-back stall", 32'(n), 32'h0);
      idle(0);

      // LATENCY=4 load followed immediately by a plain ALU op.
      run_op(3, 1'b1, 1'b1, 1'b0, 5'd11, 32'd1040, 32'h0, n, res);
      chk("k3 load stall", 32'(n), 32'd3);
      run_op(3, 1'b1, 1'b0, 1'b0, 5'd10, 32'h55, 32'h0, n, res);
      chk("k3 alu stall", 32'(n), 32'h0);
      chk("k3 alu result", a_o[3], 32'h55);
      idle(3);

      // Random traffic on every latency.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
               0: addr = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
               1: addr = 32'd1024 + 32'(4 * $urandom_range(0, 7));
               2: addr = ($urandom_range(0, 1) == 0) ? 32'd1020 : 32'd1280 + 32'(4 * $urandom_range(0, 100));
               default: addr = $urandom;
            endcase
            rw = 2'($urandom_range(0, 3));
            run_op(k, 1'($urandom_range(0, 1)), rw[0], rw[1], 5'($urandom_range(0, 31)),
                   addr, $urandom, n, res);
            if ($urandom_range(0, 3) == 0) idle(k);
         end
         idle(k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
